// File: rtl/spike_aer_arbiter_if.sv
// AER event bus between the spike arbiter and its consumer:
// valid/ready handshake carrying the zero-based firing neuron index.
interface spike_aer_arbiter_if #(
    parameter int p_addr_width = 3
);
    logic                    valid;
    logic [p_addr_width-1:0] addr;
    logic                    ready;

    modport master (output valid, output addr, input ready);
    modport slave  (input valid, input addr, output ready);
endinterface

// File: rtl/spike_aer_arbiter.sv
// Round-robin arbiter serialising per-neuron spike events onto one AER bus,
// with per-neuron pending latches and a saturating count of dropped spikes.
module spike_aer_arbiter #(
    parameter int p_neurons    = 8,
    parameter int p_addr_width = 3,
    parameter int p_cnt_width  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [p_neurons:1]     i_spike,
    input  logic                   i_enable,
    spike_aer_arbiter_if.master    aer,
    output logic                   o_busy,
    output logic                   o_drop,
    output logic [p_cnt_width-1:0] o_drop_cnt
);
    localparam int DropNumW = $clog2(p_neurons + 1);
    localparam int SumW     = p_cnt_width + DropNumW;

    typedef enum logic {IDLE, SEND} state_e;

    state_e                  state_q, state_d;
    logic [p_neurons-1:0]    pending_q, pending_d;
    logic [p_addr_width-1:0] addr_q, addr_d;
    logic [p_addr_width-1:0] lastGrant_q, lastGrant_d;
    logic                    busy_q, busy_d;
    logic                    drop_q, drop_d;
    logic [p_cnt_width-1:0]  dropCnt_q, dropCnt_d;

    logic [p_neurons-1:0]    spikeVec;
    logic [p_neurons-1:0]    rotVec;
    logic [p_neurons-1:0]    loadMask;
    logic [p_neurons-1:0]    dropVec;
    logic                    winFound;
    logic [p_addr_width-1:0] winIdx;
    logic                    load;
    logic [DropNumW-1:0]     dropNum;
    logic [SumW-1:0]         cntSum;

    assign spikeVec = i_spike;

    // Rotate pending so the neuron after the last grant sits at bit 0,
    // then the lowest set bit is the round-robin winner.
    always_comb begin
        rotVec   = p_neurons'({pending_q, pending_q} >> (int'(lastGrant_q) + 1));
        winFound = 1'b0;
        winIdx   = '0;
        for (int k = 0; k < p_neurons; k++) begin
            if (!winFound && rotVec[k]) begin
                winFound = 1'b1;
                winIdx   = p_addr_width'((int'(lastGrant_q) + 1 + k) % p_neurons);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lastGrant_d = lastGrant_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable && winFound) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (aer.ready) begin
                    if (i_enable && winFound) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        if (load) begin
            addr_d      = winIdx;
            lastGrant_d = winIdx;
        end

        // A spike on the neuron being loaded this edge is a fresh event, not a drop.
        loadMask  = load ? (p_neurons'(1) << winIdx) : '0;
        dropVec   = spikeVec & pending_q & ~loadMask;
        pending_d = spikeVec | (pending_q & ~loadMask);

        dropNum = '0;
        for (int k = 0; k < p_neurons; k++) begin
            dropNum = dropNum + DropNumW'(dropVec[k]);
        end
        cntSum    = SumW'(dropCnt_q) + SumW'(dropNum);
        dropCnt_d = (cntSum > SumW'({p_cnt_width{1'b1}})) ? '1 : cntSum[p_cnt_width-1:0];

        drop_d = |dropVec;
        busy_d = (state_d == SEND) || (|pending_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            addr_q      <= '0;
            lastGrant_q <= p_addr_width'(p_neurons - 1);
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
            dropCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            addr_q      <= addr_d;
            lastGrant_q <= lastGrant_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    assign aer.valid  = (state_q == SEND);
    assign aer.addr   = addr_q;
    assign o_busy     = busy_q;
    assign o_drop     = drop_q;
    assign o_drop_cnt = dropCnt_q;
endmodule

// File: tb/tb_spike_aer_arbiter.sv
// Self-checking bench for spike_aer_arbiter: directed vector table, corner-case
// sequences, and randomized traffic against a behavioural arbiter model.
module tb_spike_aer_arbiter;
    logic       clk = 1'b0;
    logic       rstN;
    logic [8:1] spike;
    logic       enable;
    logic       busy;
    logic       drop;
    logic [7:0] dropCnt;

    int checks = 0;
    int errors = 0;

    spike_aer_arbiter_if #(.p_addr_width(3)) aer ();

    spike_aer_arbiter #(
        .p_neurons   (8),
        .p_addr_width(3),
        .p_cnt_width (8)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rstN),
        .i_spike   (spike),
        .i_enable  (enable),
        .aer       (aer),
        .o_busy    (busy),
        .o_drop    (drop),
        .o_drop_cnt(dropCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:1] spike;
        logic       en;
        logic       rdy;
        logic       doReset;
        logic       expValid;
        logic [2:0] expAddr;
        logic       expBusy;
        logic       expDrop;
        logic [7:0] expCnt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: neurons numbered 1..8, pending kept as an integer bit mask.
    int mPend;
    bit mValid;
    int mAddr;
    int mLast;
    int mCnt;
    bit mDrop;
    bit mBusy;

    function automatic vec_t mk(input logic [8:1] sp, input logic en, input logic rdy,
                                input logic rst, input logic v, input logic [2:0] a,
                                input logic b, input logic d, input logic [7:0] c);
        vec_t r;
        r.spike = sp; r.en = en; r.rdy = rdy; r.doReset = rst;
        r.expValid = v; r.expAddr = a; r.expBusy = b; r.expDrop = d; r.expCnt = c;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic v, input logic [2:0] a,
                               input logic b, input logic d, input logic [7:0] c);
        checks++;
        if ({aer.valid, aer.addr, busy, drop, dropCnt} !== {v, a, b, d, c}) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%0b addr=%0d busy=%0b drop=%0b cnt=%0d, expected valid=%0b addr=%0d busy=%0b drop=%0b cnt=%0d",
                     name, aer.valid, aer.addr, busy, drop, dropCnt, v, a, b, d, c);
        end
    endtask

    task automatic applyStimulus(input logic [8:1] sp, input logic en, input logic rdy);
        spike     = sp;
        enable    = en;
        aer.ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        spike     = '0;
        enable    = 1'b0;
        aer.ready = 1'b0;
        rstN      = 1'b0;
        #1;
        checkOutput("reset", 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        #2;
        rstN = 1'b1;
    endtask

    task automatic modelReset();
        mPend = 0; mValid = 0; mAddr = 0; mLast = 8; mCnt = 0; mDrop = 0; mBusy = 0;
    endtask

    task automatic modelEdge(input int sp, input bit en, input bit rdy);
        int  win;
        int  drops;
        int  n;
        bit  doLoad;
        win = 0;
        for (int off = 1; off <= 8; off++) begin
            n = (mLast + off - 1) % 8 + 1;
            if (win == 0 && ((mPend >> (n - 1)) & 1) == 1) win = n;
        end
        doLoad = en && (win != 0) && (!mValid || rdy);
        drops = 0;
        for (int m = 1; m <= 8; m++) begin
            if (((sp >> (m - 1)) & 1) == 1 && ((mPend >> (m - 1)) & 1) == 1 &&
                !(doLoad && win == m))
                drops++;
        end
        if (doLoad) begin
            mPend  = mPend & ~(1 << (win - 1));
            mValid = 1;
            mAddr  = win - 1;
            mLast  = win;
        end else if (mValid && rdy) begin
            mValid = 0;
        end
        mPend = mPend | sp;
        mCnt  = (mCnt + drops > 255) ? 255 : mCnt + drops;
        mDrop = (drops > 0);
        mBusy = mValid || (mPend != 0);
    endtask

    initial begin
        logic [8:1] sp;
        logic       en;
        logic       rdy;
        int         expCnt;

        rstN      = 1'b1;
        spike     = '0;
        enable    = 1'b0;
        aer.ready = 1'b0;
        @(posedge clk);
        #1;
        applyReset();

        // Directed table: single spike, simultaneous spikes, fairness wrap,
        // same-cycle reload, enable gating, enable dropped during SEND.
        vecs.push_back(mk(8'b00000100, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00010011, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00100001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000010, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000010, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00001000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00010001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 8'd0));
        vecs.push_back(mk(8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd0));

        foreach (vecs[i]) begin
            if (vecs[i].doReset) applyReset();
            applyStimulus(vecs[i].spike, vecs[i].en, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expAddr,
                        vecs[i].expBusy, vecs[i].expDrop, vecs[i].expCnt);
        end

        // Backpressure: neuron 1 spikes every 10 cycles while the bus is stalled.
        applyReset();
        applyStimulus(8'b00000001, 1'b1, 1'b0);
        checkOutput("bp_capture", 1'b0, 3'd0, 1'b1, 1'b0, 8'd0);
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        checkOutput("bp_load", 1'b1, 3'd0, 1'b1, 1'b0, 8'd0);
        for (int s = 2; s <= 4; s++) begin
            repeat (8) applyStimulus(8'b00000000, 1'b1, 1'b0);
            applyStimulus(8'b00000001, 1'b1, 1'b0);
            expCnt = (s >= 3) ? s - 2 : 0;
            checkOutput($sformatf("bp_spike%0d", s), 1'b1, 3'd0, 1'b1, (s >= 3), 8'(expCnt));
            applyStimulus(8'b00000000, 1'b1, 1'b0);
            checkOutput($sformatf("bp_after%0d", s), 1'b1, 3'd0, 1'b1, 1'b0, 8'(expCnt));
        end
        applyStimulus(8'b00000000, 1'b1, 1'b1);
        checkOutput("bp_second_addr0", 1'b1, 3'd0, 1'b1, 1'b0, 8'd2);
        applyStimulus(8'b00000000, 1'b1, 1'b1);
        checkOutput("bp_drain", 1'b0, 3'd0, 1'b0, 1'b0, 8'd2);

        // Saturation: 300 drops on neuron 2 while neuron 1 holds the bus.
        applyReset();
        applyStimulus(8'b00000001, 1'b1, 1'b0);
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        applyStimulus(8'b00000010, 1'b1, 1'b0);
        checkOutput("sat_pending", 1'b1, 3'd0, 1'b1, 1'b0, 8'd0);
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(8'b00000010, 1'b1, 1'b0);
            checkOutput($sformatf("sat_drop%0d", i), 1'b1, 3'd0, 1'b1, 1'b1,
                        8'((i > 255) ? 255 : i));
        end
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        checkOutput("sat_hold", 1'b1, 3'd0, 1'b1, 1'b0, 8'd255);

        // Asynchronous reset between edges while SEND is active with work pending.
        applyReset();
        applyStimulus(8'b00001111, 1'b1, 1'b0);
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        applyStimulus(8'b00000010, 1'b1, 1'b0);
        checkOutput("pre_reset", 1'b1, 3'd0, 1'b1, 1'b1, 8'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 1'b0, 3'd0, 1'b0, 1'b0, 8'd0);
        rstN = 1'b1;
        applyStimulus(8'b10000000, 1'b1, 1'b1);
        checkOutput("post_reset_capture", 1'b0, 3'd0, 1'b1, 1'b0, 8'd0);
        applyStimulus(8'b00000000, 1'b1, 1'b1);
        checkOutput("post_reset_n8", 1'b1, 3'd7, 1'b1, 1'b0, 8'd0);
        applyStimulus(8'b00000000, 1'b1, 1'b1);
        checkOutput("post_reset_drain", 1'b0, 3'd7, 1'b0, 1'b0, 8'd0);

        // Randomized traffic with stall windows to provoke drops.
        applyReset();
        modelReset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            sp  = 8'($urandom) & 8'($urandom);
            en  = ($urandom_range(7) != 0);
            rdy = ((cyc % 200) < 40) ? 1'b0 : ($urandom_range(3) != 0);
            applyStimulus(sp, en, rdy);
            modelEdge(int'(sp), en, rdy);
            checkOutput($sformatf("random%0d", cyc), mValid, 3'(mAddr), mBusy, mDrop, 8'(mCnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/spike_aer_arbiter.md
Name: spike_aer_arbiter

Overview:
- Round-robin arbiter that shares one address-event (AER) output bus among the spike outputs of the 8 neurons in the tinySNN array.
- Each neuron firing pulse is captured in a per-neuron pending latch.
- Pending events are serialised onto a valid/ready bus carrying the firing neuron index.
- Spikes that arrive while the same neuron's event is still unserved are counted as drops.

Parameters:
- p_neurons, 8: number of neuron spike inputs.
- p_addr_width, 3: width of the AER address; must satisfy 2**p_addr_width >= p_neurons.
- p_cnt_width, 8: width of the saturating drop counter.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_spike  in  [p_neurons:1]  per-neuron firing pulses, synchronous to i_clk, sampled every edge; bit n = neuron n.
- i_enable  in  1  when 0, no new grant is issued; spike capture continues.
- i_aer_ready  in  1  downstream accepts the current event.
- o_aer_valid  out  1  event present on o_aer_addr.
- o_aer_addr  out  p_addr_width  firing neuron index minus 1 (neuron 1 -> 0).
- o_busy  out  1  o_aer_valid OR any pending bit set (registered).
- o_drop  out  1  one-cycle pulse: at least one spike was dropped on the previous edge.
- o_drop_cnt  out  p_cnt_width  total dropped spikes, saturating.

Behaviour:
- Reset is asynchronous. On assertion, all state and outputs clear immediately:
  - pending = 0, o_aer_valid = 0, o_aer_addr = 0, o_busy = 0, o_drop = 0, o_drop_cnt = 0.
  - Round-robin pointer last_grant = p_neurons, so the first search starts at neuron 1.
  - FSM goes to IDLE; any in-flight event is discarded.
- Pending capture, per neuron n, each edge:
  - Sampling i_spike[n] = 1 sets pending[n].
  - pending[n] clears when n is loaded into the output register, not at handshake.
  - If n is loaded in the same cycle that i_spike[n] = 1, pending[n] stays 1 (new event) and this is not a drop.
- Drop rule:
  - i_spike[n] = 1 while pending[n] = 1 and n is not being loaded that cycle counts as one drop.
  - Multiple neurons dropping in the same cycle add their count together.
  - o_drop_cnt saturates at all-ones.
  - o_drop is registered and asserts the cycle after the drop edge.
- FSM states: IDLE and SEND.
  - IDLE: if i_enable = 1 and any pending bit is set, select the winner, load o_aer_addr = winner - 1, set o_aer_valid = 1, clear pending[winner], set last_grant = winner, and move to SEND. Otherwise stay in IDLE with o_aer_valid = 0.
  - SEND: hold o_aer_valid and o_aer_addr stable while i_aer_ready = 0. On handshake (valid AND ready at an edge), either load the next winner in the same edge (back-to-back, valid stays 1) if i_enable = 1 and pending is nonzero, or drop o_aer_valid to 0 and return to IDLE.
- Winner selection: search pending from last_grant+1 up to p_neurons, then wrap to 1 up to last_grant. The first set bit wins. Selection uses the pending register as it stood before this edge; spikes arriving in the current cycle are not visible to it.
- Latency: a spike sampled at edge k sets pending; from IDLE, o_aer_valid is asserted after edge k+1. Minimum spike-to-valid latency is 2 cycles.
- Throughput: one event per cycle while i_aer_ready = 1 and events are pending.
- i_enable deasserted during SEND: the current event still completes its handshake, then the FSM returns to IDLE and pending is held.
- o_aer_addr holds its last value when o_aer_valid = 0.
- o_busy is registered from next-state valid OR next-state pending.

Test Plan:
- Single spike on neuron 3 at edge k, i_aer_ready = 1 -> o_aer_valid = 1 with o_aer_addr = 2 after edge k+1, for exactly 1 cycle. o_busy = 1 for 2 cycles. o_drop_cnt = 0.
- Simultaneous spikes on neurons 1, 2 and 5 after reset, ready = 1 -> addrs 0, 1, 4 on consecutive cycles with valid continuously high. Valid low on the 4th cycle.
- Fairness: neuron 5 just granted, then neurons 1 and 6 pending -> addr 5 is issued before addr 0.
- Backpressure: ready = 0, neuron 1 spikes 4 times at 10-cycle spacing -> first spike is loaded (addr 0 held). Second spike sets pending. Third and fourth are dropped: o_drop pulses twice and o_drop_cnt = 2. Raising ready then yields addr 0 twice.
- Saturation: force 300 drops on neuron 2 -> o_drop_cnt stops at 255 and o_drop still pulses on each drop.
- Reset mid-SEND (valid = 1, 3 bits pending), i_rst_n = 0 between clock edges -> all outputs 0 immediately. After release, a spike on neuron 8 yields addr 7, confirming the search restarts from neuron 1.
